alu_driver: RTL and testbench
=============================

ALU_DRIVER -- requirements
Module: alu_driver

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width.
REQ-002 SHALL have parameter TIMEOUT, default 8, max cycles from alu_en to alu_ready before error (legal range 3..255).
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  1  upstream operation request valid.
REQ-006 SHALL have port req_ready  output  1  driver can accept a request.
REQ-007 SHALL have port req_cmd  input  4  opcode passed to the ALU; bit 3 selects accumulate.
REQ-008 SHALL have ports req_a, req_b  input  WIDTH  operands.
REQ-009 SHALL have ports alu_cmd (4), alu_a, alu_b (WIDTH)  output  operation presented to the ALU.
REQ-010 SHALL have port alu_en  output  1  one-cycle launch strobe to the ALU.
REQ-011 SHALL have port alu_result  input  WIDTH  ALU result, valid when alu_ready=1.
REQ-012 SHALL have port alu_ready  input  1  ALU completion strobe.
REQ-013 SHALL have port rsp_valid  output  1  response available.
REQ-014 SHALL have port rsp_ready  input  1  downstream accepts response.
REQ-015 SHALL have port rsp_data  output  WIDTH  captured ALU result (0 on error).
REQ-016 SHALL have port rsp_err  output  1  response is a timeout error.
REQ-017 SHALL have port op_count  output  16  number of responses accepted downstream since reset.

Function
REQ-018 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP; exactly one operation outstanding.
REQ-019 IDLE: req_ready=1; on req_valid&req_ready capture cmd/a/b into registers, go to ISSUE.
REQ-020 ISSUE: alu_en=1 for exactly this one cycle, alu_cmd/alu_a/alu_b driven from captured registers; next state WAIT; wait counter cleared to 0.
REQ-021 alu_cmd/alu_a/alu_b SHALL hold captured values stable from ISSUE through WAIT.
REQ-022 WAIT: counter increments each cycle; alu_ready=1 -> capture alu_result into rsp_data, rsp_err=0, go to RESP.
REQ-023 WAIT: counter reaching TIMEOUT with alu_ready=0 -> rsp_data=0, rsp_err=1, go to RESP; alu_ready in that same cycle takes priority (success).
REQ-024 Nominal ALU latency: alu_ready seen in the 2nd cycle after the ISSUE cycle; request accepted at edge N yields rsp_valid from cycle N+4.
REQ-025 RESP: rsp_valid=1, rsp_data/rsp_err stable until rsp_valid&rsp_ready; then op_count+1 (wraps 0xFFFF->0) and go to IDLE.
REQ-026 req_ready SHALL be 0 in ISSUE, WAIT, RESP; no request accepted in the RESP handshake cycle (next accept earliest the following cycle).
REQ-027 alu_ready outside WAIT SHALL be ignored (no state change, rsp_data unchanged).
REQ-028 alu_en SHALL never be asserted outside ISSUE.
REQ-029 rsp_valid SHALL not depend combinationally on rsp_ready.

Reset
REQ-030 reset=1 at a clock edge SHALL force IDLE, alu_en=0, rsp_valid=0, rsp_err=0, rsp_data=0, op_count=0, captured cmd/a/b=0, counter=0, from any state.
REQ-031 reset SHALL override all simultaneous inputs (req_valid, alu_ready, rsp_ready); an aborted operation produces no response.
REQ-032 req_ready SHALL be 0 while reset=1 and 1 in the first cycle after reset deasserts.

Verification
REQ-033 WIDTH=16, ALU model latency 2: req cmd=0 a=5 b=7 -> one alu_en pulse, alu_cmd=0, rsp_data=12, rsp_err=0, rsp_valid 4 cycles after accept, op_count=1.
REQ-034 rsp_ready held 0 for 5 cycles -> rsp_valid/rsp_data stable, req_ready=0 throughout; no second alu_en.
REQ-035 ALU model never asserts ready, TIMEOUT=8 -> rsp_err=1, rsp_data=0 after 8 WAIT cycles; next request completes normally.
REQ-036 Back-to-back: 3 requests with req_valid held high, rsp_ready=1 -> exactly 3 alu_en pulses, responses in order, op_count=3.
REQ-037 Assert reset during WAIT -> no response, outputs at reset values next cycle, spurious late alu_ready ignored.
REQ-038 Preload op_count to 0xFFFF via 65535 ops (or forced) -> one more accepted response wraps op_count to 0.

Source files
------------

// File: rtl/alu_driver.sv
// Single-outstanding request driver for a multi-cycle ALU.
// It launches each operation with a one-cycle strobe, then waits for the ALU to finish or times out.
module alu_driver #(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_cmd,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic [3:0]       alu_cmd,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_en,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_ready,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err,
    output logic [15:0]      op_count
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    // The counter's terminal value is TIMEOUT-1 because WAIT cycles are numbered from 0.
    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    state_t     state;
    logic [7:0] wait_count;

    assign req_ready = (state == IDLE) && !reset;

    // The captured operands live directly in the alu_* output registers, so they stay stable until the next accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            alu_cmd    <= 4'd0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_en     <= 1'b0;
            wait_count <= 8'd0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
            op_count   <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        alu_cmd <= req_cmd;
                        alu_a   <= req_a;
                        alu_b   <= req_b;
                        alu_en  <= 1'b1;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    alu_en     <= 1'b0;
                    wait_count <= 8'd0;
                    state      <= WAIT;
                end
                WAIT: begin
                    // A completion in the last allowed cycle still counts as success.
                    if (alu_ready) begin
                        rsp_data  <= alu_result;
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else if (wait_count == LAST_WAIT) begin
                        rsp_data  <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        wait_count <= wait_count + 8'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        op_count  <= op_count + 16'd1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_driver.sv
// Bench for alu_driver: a latency-programmable ALU model, a response scoreboard checked every cycle,
// and directed scenarios with hand-computed expectations.
module tb_alu_driver;

    localparam int WIDTH   = 16;
    localparam int TIMEOUT = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             req_valid;
    logic             req_ready;
    logic [3:0]       req_cmd;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic [3:0]       alu_cmd;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic             alu_en;
    logic [WIDTH-1:0] alu_result = 16'hDEAD;
    logic             alu_ready  = 1'b0;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_err;
    logic [15:0]      op_count;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int en_pulses = 0;
    int accept_cyc = 0;

    int               alu_lat = 2;
    int               alu_cnt = 0;
    logic             spur_ready = 1'b0;
    logic [WIDTH-1:0] alu_hold;

    logic [WIDTH:0]   exp_q[$];
    logic [15:0]      model_count = 16'd0;
    logic             accepted_prev = 1'b0;
    logic             rst_last = 1'b0;
    logic             in_op = 1'b0;
    logic [3:0]       acc_cmd;
    logic [WIDTH-1:0] acc_a;
    logic [WIDTH-1:0] acc_b;

    always #5 clk = ~clk;

    alu_driver #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_cmd(req_cmd), .req_a(req_a), .req_b(req_b),
        .alu_cmd(alu_cmd), .alu_a(alu_a), .alu_b(alu_b), .alu_en(alu_en),
        .alu_result(alu_result), .alu_ready(alu_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .op_count(op_count)
    );

    function automatic logic [WIDTH-1:0] aluOp(input logic [3:0] cmd, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        case (cmd[2:0])
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return a;
            3'd6:    return b;
            default: return ~a;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(posedge clk) cyc++;

    // ALU model: raises ready alu_lat cycles after the launch cycle; alu_lat of 0 means it never answers.
    always @(posedge clk) begin
        #1;
        alu_ready  = spur_ready;
        alu_result = 16'hDEAD;
        if (alu_en) begin
            alu_cnt  = alu_lat;
            alu_hold = aluOp(alu_cmd, alu_a, alu_b);
        end else if (alu_cnt > 0) begin
            alu_cnt--;
            if (alu_cnt == 0) begin
                alu_ready  = 1'b1;
                alu_result = alu_hold;
            end
        end
    end

    // Every-cycle comparison against the transaction-level model.
    always @(negedge clk) begin
        if (rst_last) begin
            checkOutput("rst_rsp_valid", rsp_valid, 0);
            checkOutput("rst_alu_en", alu_en, 0);
            checkOutput("rst_rsp_err", rsp_err, 0);
            checkOutput("rst_rsp_data", rsp_data, 0);
        end
        if (reset)
            checkOutput("req_ready_in_reset", req_ready, 0);
        else if (rst_last)
            checkOutput("req_ready_after_reset", req_ready, 1);
        checkOutput("op_count", op_count, model_count);
        checkOutput("alu_en_after_accept", alu_en, accepted_prev);
        if (alu_en) begin
            en_pulses++;
            in_op = 1'b1;
        end
        if (in_op && !rsp_valid) begin
            checkOutput("req_ready_busy", req_ready, 0);
            checkOutput("alu_cmd", alu_cmd, acc_cmd);
            checkOutput("alu_a", alu_a, acc_a);
            checkOutput("alu_b", alu_b, acc_b);
        end
        if (rsp_valid) begin
            in_op = 1'b0;
            checkOutput("req_ready_in_resp", req_ready, 0);
            if (exp_q.size() == 0) begin
                checkOutput("rsp_valid_unexpected", rsp_valid, 0);
            end else begin
                checkOutput("rsp_data", rsp_data, exp_q[0][WIDTH-1:0]);
                checkOutput("rsp_err", rsp_err, exp_q[0][WIDTH]);
                if (rsp_ready && !reset) begin
                    void'(exp_q.pop_front());
                    model_count++;
                end
            end
        end
        accepted_prev = req_valid && req_ready && !reset;
        if (accepted_prev) begin
            acc_cmd = req_cmd;
            acc_a   = req_a;
            acc_b   = req_b;
            if (alu_lat == 0 || alu_lat > TIMEOUT)
                exp_q.push_back({1'b1, {WIDTH{1'b0}}});
            else
                exp_q.push_back({1'b0, aluOp(req_cmd, req_a, req_b)});
        end
        if (reset) begin
            exp_q.delete();
            model_count   = 16'd0;
            accepted_prev = 1'b0;
            in_op         = 1'b0;
        end
        rst_last = reset;
    end

    task automatic applyStimulus(input logic [3:0] cmd, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit hold);
        bit ok = 0;
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_cmd   = cmd;
        req_a     = a;
        req_b     = b;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1;
                accept_cyc = cyc;
                break;
            end
        end
        if (!ok) checkOutput("accept_timeout", req_ready, 1);
        @(posedge clk); #1;
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic waitResponse(output int latency);
        bit ok = 0;
        latency = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                ok = 1;
                latency = cyc - accept_cyc;
                break;
            end
        end
        if (!ok) checkOutput("rsp_timeout", rsp_valid, 1);
    endtask

    initial begin
        int lat;
        int e0;
        reset     = 1'b1;
        req_valid = 1'b1;
        req_cmd   = 4'hF;
        req_a     = 16'h1111;
        req_b     = 16'h2222;
        rsp_ready = 1'b1;
        spur_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset      = 1'b0;
        req_valid  = 1'b0;
        spur_ready = 1'b0;
        @(negedge clk);
        checkOutput("post_reset_req_ready", req_ready, 1);
        checkOutput("post_reset_op_count", op_count, 0);

        // Nominal add with latency-2 ALU.
        e0 = en_pulses;
        applyStimulus(4'd0, 16'd5, 16'd7, 0);
        waitResponse(lat);
        checkOutput("t1_latency", lat, 4);
        checkOutput("t1_data", rsp_data, 16'd12);
        checkOutput("t1_err", rsp_err, 0);
        @(negedge clk);
        checkOutput("t1_op_count", op_count, 1);
        checkOutput("t1_en_pulses", en_pulses - e0, 1);

        // Backpressure with a new request already waiting upstream.
        rsp_ready = 1'b0;
        e0 = en_pulses;
        applyStimulus(4'd1, 16'd20, 16'd3, 1);
        req_cmd = 4'd2;
        req_a   = 16'hF0F0;
        req_b   = 16'hFF00;
        waitResponse(lat);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("t2_hold_valid", rsp_valid, 1);
            checkOutput("t2_hold_data", rsp_data, 16'd17);
            checkOutput("t2_hold_req_ready", req_ready, 0);
        end
        checkOutput("t2_en_pulses", en_pulses - e0, 1);
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        applyStimulus(4'd2, 16'hF0F0, 16'hFF00, 0);
        waitResponse(lat);
        checkOutput("t2_second_data", rsp_data, 16'hF000);
        @(negedge clk);
        checkOutput("t2_op_count", op_count, 3);

        // Timeout, last-cycle success, one-past-timeout, then recovery.
        alu_lat = 0;
        applyStimulus(4'd0, 16'd1, 16'd1, 0);
        waitResponse(lat);
        checkOutput("t3_timeout_latency", lat, 2 + TIMEOUT);
        checkOutput("t3_timeout_err", rsp_err, 1);
        checkOutput("t3_timeout_data", rsp_data, 0);
        alu_lat = TIMEOUT;
        applyStimulus(4'd4, 16'h1234, 16'h00FF, 0);
        waitResponse(lat);
        checkOutput("t3_edge_latency", lat, 2 + TIMEOUT);
        checkOutput("t3_edge_err", rsp_err, 0);
        checkOutput("t3_edge_data", rsp_data, 16'h12CB);
        alu_lat = TIMEOUT + 1;
        applyStimulus(4'd0, 16'd2, 16'd3, 0);
        waitResponse(lat);
        checkOutput("t3_late_err", rsp_err, 1);
        checkOutput("t3_late_data", rsp_data, 0);
        alu_lat = 2;
        applyStimulus(4'd1, 16'd0, 16'd1, 0);
        waitResponse(lat);
        checkOutput("t3_recover_latency", lat, 4);
        checkOutput("t3_recover_data", rsp_data, 16'hFFFF);
        checkOutput("t3_recover_err", rsp_err, 0);

        // Back-to-back with req_valid held high.
        e0 = en_pulses;
        applyStimulus(4'd0, 16'd100, 16'd200, 1);
        applyStimulus(4'd3, 16'h00F0, 16'h0F00, 1);
        applyStimulus(4'd5, 16'hABCD, 16'h0000, 0);
        waitResponse(lat);
        checkOutput("t4_last_data", rsp_data, 16'hABCD);
        @(negedge clk);
        checkOutput("t4_op_count", op_count, 10);
        checkOutput("t4_en_pulses", en_pulses - e0, 3);

        // Reset during WAIT; the ALU's late ready must be ignored.
        alu_lat = 5;
        applyStimulus(4'd0, 16'd9, 16'd9, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checkOutput("t5_no_rsp", rsp_valid, 0);
        end
        checkOutput("t5_rsp_data", rsp_data, 0);
        checkOutput("t5_op_count", op_count, 0);
        alu_lat = 2;
        applyStimulus(4'd0, 16'd5, 16'd7, 0);
        waitResponse(lat);
        checkOutput("t5_after_data", rsp_data, 16'd12);
        @(negedge clk);
        checkOutput("t5_after_count", op_count, 1);

        // op_count wrap from 0xFFFF.
        @(posedge clk); #1;
        force dut.op_count = 16'hFFFF;
        model_count = 16'hFFFF;
        @(negedge clk);
        release dut.op_count;
        @(negedge clk);
        checkOutput("t6_preload", op_count, 16'hFFFF);
        applyStimulus(4'd2, 16'hFFFF, 16'h0F0F, 0);
        waitResponse(lat);
        checkOutput("t6_data", rsp_data, 16'h0F0F);
        @(negedge clk);
        checkOutput("t6_wrap", op_count, 0);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got %0d tests, expected completion", tests);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
